// File: rtl/control_unit.sv
// Multi-cycle sequencer: owns the PC, the instruction register, the zero flag and the write-back strobe.
// Latency: 4 cycles per executed ALU instruction (FETCH/DECODE/EXEC/WB), 2 per skipped instruction or jump.
// No backpressure: ROM and register bank are assumed single-cycle; start is only honoured in IDLE/HALT.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           level; launches a run from IDLE or restarts from HALT
//   inst            ROM data for the current address
//   alu_zero        combinational ALU zero result, latched at write-back
//   mem_en          ROM enable (FETCH only)
//   address         ROM address, equal to the PC register
//   ir              instruction register driving the interpreter
//   reg_we          register-bank write strobe (WB only)
//   halted          high while in HALT
//   state           registered FSM state
//   inst_count      retired instructions, saturating at 255
module control_unit #(
    parameter int          ADDR_W   = 4,
    parameter int          PROG_LEN = 9,
    parameter logic [3:0]  HALT_OP  = 4'hF,
    parameter logic [3:0]  JMP_OP   = 4'hE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       inst,
    input  logic              alu_zero,
    output logic              mem_en,
    output logic [ADDR_W-1:0] address,
    output logic [15:0]       ir,
    output logic              reg_we,
    output logic              halted,
    output logic [2:0]        state,
    output logic [7:0]        inst_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);
    // One extra bit so PROG_LEN == 2**ADDR_W is representable for the jump range check.
    localparam logic [ADDR_W:0]   PROG_LEN_W = (ADDR_W + 1)'(PROG_LEN);

    logic [ADDR_W-1:0] pc;
    logic              zflag;
    logic [1:0]        cond;
    logic [3:0]        op;
    logic [ADDR_W-1:0] jmp_target;
    logic              cond_true;
    logic              target_ok;
    logic              at_last;
    logic [7:0]        count_inc;

    assign cond       = ir[15:14];
    assign op         = ir[13:10];
    assign jmp_target = ir[ADDR_W-1:0];
    assign target_ok  = ({1'b0, jmp_target} < PROG_LEN_W);
    assign at_last    = (pc == LAST_PC);
    assign count_inc  = (inst_count == 8'hFF) ? inst_count : inst_count + 8'd1;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = zflag;
            2'b10:   cond_true = ~zflag;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            zflag      <= 1'b0;
            inst_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    ir    <= inst;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (op == HALT_OP) begin
                        state <= S_HALT;
                    end else if (!cond_true) begin
                        // Skipped: end-of-program is tested before the increment so PC never wraps.
                        if (at_last) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end else if (op == JMP_OP) begin
                        inst_count <= count_inc;
                        if (target_ok) begin
                            pc    <= jmp_target;
                            state <= S_FETCH;
                        end else begin
                            state <= S_HALT;
                        end
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_WB;
                end
                S_WB: begin
                    zflag      <= alu_zero;
                    inst_count <= count_inc;
                    if (at_last) begin
                        state <= S_HALT;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        zflag <= 1'b0;
                        state <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from registered state only.
    assign mem_en  = (state == S_FETCH);
    assign reg_we  = (state == S_WB);
    assign halted  = (state == S_HALT);
    assign address = pc;

endmodule
